// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared constants, clear-FSM state encoding and byte-merge helper
//           for the multiport register file.
// Revision: 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int C_DATA_W_DEF = 32;
    localparam int C_ADDR_W_DEF = 5;
    localparam int C_NRD_DEF    = 2;

    // The merge helper works on a fixed maximum width; callers extend/truncate.
    localparam int C_MERGE_W  = 256;
    localparam int C_MERGE_BE = C_MERGE_W / 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clear_state_t;

    function automatic logic [C_MERGE_W-1:0] merge_bytes(
        input logic [C_MERGE_W-1:0]  old_data,
        input logic [C_MERGE_W-1:0]  new_data,
        input logic [C_MERGE_BE-1:0] be
    );
        logic [C_MERGE_W-1:0] res;
        res = old_data;
        for (int i = 0; i < C_MERGE_BE; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module  : regfile_clear_fsm
// Brief   : Clear-sweep sequencer: walks every register once, flags busy and
//           reports write requests that had to be discarded.
// Revision: 1.0  initial release
// ============================================================================
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    input  logic              write_req,
    output logic              sweep_en,
    output logic [ADDR_W-1:0] sweep_idx,
    output logic              write_ok,
    output logic              clear_busy,
    output logic              write_dropped
);

    localparam logic [ADDR_W:0] C_LAST_IDX = (ADDR_W+1)'((2**ADDR_W) - 1);

    clear_state_t    r_state;
    logic [ADDR_W:0] r_idx;
    logic            r_busy;
    logic            r_dropped;

    // A clear accepted this edge takes priority over a simultaneous write.
    assign write_ok      = (r_state == ST_IDLE) && !clear_req;
    assign sweep_en      = (r_state == ST_CLEAR);
    assign sweep_idx     = r_idx[ADDR_W-1:0];
    assign clear_busy    = r_busy;
    assign write_dropped = r_dropped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= write_req && !write_ok;
            case (r_state)
                ST_IDLE: begin
                    if (clear_req) begin
                        r_state <= ST_CLEAR;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == C_LAST_IDX) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module  : regfile_multiport
// Brief   : Byte-writable register file with NRD combinational read ports,
//           optional hardwired register 0, write-first bypass and clear sweep.
// Revision: 1.0  initial release
// ============================================================================
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W    = C_DATA_W_DEF,
    parameter int ADDR_W    = C_ADDR_W_DEF,
    parameter int NRD       = C_NRD_DEF,
    parameter int ZERO_REG0 = 1,
    parameter int BYPASS    = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  ctrl_writeEn,
    input  logic [ADDR_W-1:0]     ctrl_writeReg,
    input  logic [DATA_W/8-1:0]   ctrl_byteEn,
    input  logic [DATA_W-1:0]     data_writeReg,
    input  logic [NRD*ADDR_W-1:0] ctrl_readReg,
    output logic [NRD*DATA_W-1:0] data_readReg,
    input  logic                  ctrl_clear,
    output logic                  clear_busy,
    output logic                  write_dropped
);

    localparam int C_DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [C_DEPTH];

    logic              w_sweep_en;
    logic [ADDR_W-1:0] w_sweep_idx;
    logic              w_write_ok;
    logic              w_write_go;
    logic [DATA_W-1:0] w_wr_merged;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk           (clock),
        .rst_n         (ctrl_reset_n),
        .clear_req     (ctrl_clear),
        .write_req     (ctrl_writeEn),
        .sweep_en      (w_sweep_en),
        .sweep_idx     (w_sweep_idx),
        .write_ok      (w_write_ok),
        .clear_busy    (clear_busy),
        .write_dropped (write_dropped)
    );

    // Hardwired register 0 swallows writes without counting them as dropped.
    assign w_write_go  = ctrl_writeEn && w_write_ok &&
                         !((ZERO_REG0 != 0) && (ctrl_writeReg == '0));
    assign w_wr_merged = DATA_W'(merge_bytes(C_MERGE_W'(r_mem[ctrl_writeReg]),
                                             C_MERGE_W'(data_writeReg),
                                             C_MERGE_BE'(ctrl_byteEn)));

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_sweep_en) begin
            r_mem[w_sweep_idx] <= '0;
        end else if (w_write_go) begin
            r_mem[ctrl_writeReg] <= w_wr_merged;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_is_zero;
        logic              w_hit;

        assign w_addr    = ctrl_readReg[p*ADDR_W +: ADDR_W];
        assign w_is_zero = (ZERO_REG0 != 0) && (w_addr == '0);
        assign w_hit     = (BYPASS != 0) && w_write_go && (w_addr == ctrl_writeReg);
        assign data_readReg[p*DATA_W +: DATA_W] =
            w_is_zero ? '0 : (w_hit ? w_wr_merged : r_mem[w_addr]);
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_multiport
// Brief   : Self-checking bench: two register-file configurations against a
//           cycle-level behavioural model plus directed literal expectations.
// Revision: 1.0  initial release
// ============================================================================
module tb_regfile_multiport;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          rst_n = 1'b1;
    logic          wen   = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [3:0]    be    = '0;
    logic [DW-1:0] wdata = '0;
    logic          clr   = 1'b0;

    logic [2*AW-1:0] rd_a = '0;
    logic [2*DW-1:0] dout_a;
    logic            busy_a, drop_a;
    logic [4*AW-1:0] rd_b = '0;
    logic [4*DW-1:0] dout_b;
    logic            busy_b, drop_b;

    // A: defaults (hardwired reg0, bypass). B: four ports, ordinary reg0, no bypass.
    regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .ZERO_REG0(1), .BYPASS(1)) dut_a (
        .clock(clock), .ctrl_reset_n(rst_n), .ctrl_writeEn(wen), .ctrl_writeReg(waddr),
        .ctrl_byteEn(be), .data_writeReg(wdata), .ctrl_readReg(rd_a), .data_readReg(dout_a),
        .ctrl_clear(clr), .clear_busy(busy_a), .write_dropped(drop_a));

    regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .NRD(4), .ZERO_REG0(0), .BYPASS(0)) dut_b (
        .clock(clock), .ctrl_reset_n(rst_n), .ctrl_writeEn(wen), .ctrl_writeReg(waddr),
        .ctrl_byteEn(be), .data_writeReg(wdata), .ctrl_readReg(rd_b), .data_readReg(dout_b),
        .ctrl_clear(clr), .clear_busy(busy_b), .write_dropped(drop_b));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] ma [DEPTH];
    logic [31:0] mb [DEPTH];
    bit          m_busy;
    int          m_pos;
    bit          m_drop;
    bit          model_live = 1'b0;

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] e);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = e[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ma[i] <= '0;
                mb[i] <= '0;
            end
            m_busy <= 1'b0;
            m_pos  <= 0;
            m_drop <= 1'b0;
        end else begin
            m_drop <= wen && (m_busy || clr);
            if (m_busy) begin
                ma[m_pos] <= '0;
                mb[m_pos] <= '0;
                m_pos     <= m_pos + 1;
                if (m_pos == DEPTH - 1) m_busy <= 1'b0;
            end else if (clr) begin
                m_busy <= 1'b1;
                m_pos  <= 0;
            end else if (wen) begin
                if (waddr != 0) ma[waddr] <= mrg(ma[waddr], wdata, be);
                mb[waddr] <= mrg(mb[waddr], wdata, be);
            end
        end
    end

    function automatic logic [31:0] exp_a(input logic [AW-1:0] a);
        if (a == 0) return 32'h0;
        if (wen && !m_busy && !clr && a == waddr) return mrg(ma[a], wdata, be);
        return ma[a];
    endfunction

    always @(negedge clock) begin
        if (rst_n && model_live) begin
            for (int p = 0; p < 2; p++)
                check($sformatf("model_rdA%0d", p), dout_a[p*DW +: DW], exp_a(rd_a[p*AW +: AW]));
            for (int p = 0; p < 4; p++)
                check($sformatf("model_rdB%0d", p), dout_b[p*DW +: DW], mb[rd_b[p*AW +: AW]]);
            check("model_busyA", 32'(busy_a), 32'(m_busy));
            check("model_dropA", 32'(drop_a), 32'(m_drop));
            check("model_busyB", 32'(busy_b), 32'(m_busy));
            check("model_dropB", 32'(drop_b), 32'(m_drop));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] e);
        wen = 1'b1; waddr = a; wdata = d; be = e;
        step();
        wen = 1'b0;
    endtask

    task automatic mid();
        @(negedge clock);
        #1;
    endtask

    int drops_seen;
    int busy_cnt;
    int drop_cnt;

    initial begin
        // reset for two cycles
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_rdA0", dout_a[31:0], 32'h0);
        check("reset_busy", 32'(busy_a), 32'h0);
        check("reset_drop", 32'(drop_a), 32'h0);
        rst_n = 1'b1;
        model_live = 1'b1;
        step();

        // 1: fill all registers
        drops_seen = 0;
        for (int a = 0; a < DEPTH; a++) begin
            wen = 1'b1; waddr = AW'(a); wdata = 32'h0000_DEAD; be = 4'hF;
            mid();
            if (drop_a) drops_seen++;
            step();
        end
        wen = 1'b0;
        mid();
        if (drop_a) drops_seen++;
        check("fill_no_drop", 32'(drops_seen), 32'h0);
        rd_a = {AW'(17), AW'(0)};
        rd_b = {AW'(3), AW'(31), AW'(17), AW'(0)};
        mid();
        check("fill_reg0_A", dout_a[31:0], 32'h0);
        check("fill_reg17_A", dout_a[63:32], 32'h0000_DEAD);
        check("fill_reg0_B", dout_b[31:0], 32'h0000_DEAD);
        step();

        // 2: byte-enable merge, then an all-zero byte mask
        wr(5, 32'h1122_3344, 4'hF);
        wr(5, 32'hAABB_CCDD, 4'b0101);
        rd_a = {AW'(5), AW'(5)};
        mid();
        check("byteen_merge", dout_a[31:0], 32'h11BB_33DD);
        step();
        wr(5, 32'hFFFF_FFFF, 4'b0000);
        mid();
        check("byteen_none", dout_a[63:32], 32'h11BB_33DD);
        check("byteen_none_nodrop", 32'(drop_a), 32'h0);
        step();

        // 3: bypass vs no-bypass on reg7
        wen = 1'b1; waddr = 7; wdata = 32'hCAFE_F00D; be = 4'hF;
        rd_a = {AW'(1), AW'(7)};
        rd_b = {AW'(0), AW'(0), AW'(0), AW'(7)};
        mid();
        check("bypass_A", dout_a[31:0], 32'hCAFE_F00D);
        check("nobypass_B_before", dout_b[31:0], 32'h0000_DEAD);
        step();
        wen = 1'b0;
        mid();
        check("nobypass_B_after", dout_b[31:0], 32'hCAFE_F00D);
        step();

        // 4: clear sweep with a write in sweep cycle 4 and a stray clear in cycle 10
        clr = 1'b1;
        step();
        clr = 1'b0;
        busy_cnt = 0;
        drop_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            wen = (c == 4); waddr = 3; wdata = 32'h3333_3333; be = 4'hF;
            clr = (c == 10);
            mid();
            if (busy_a) busy_cnt++;
            if (drop_a) drop_cnt++;
            step();
        end
        wen = 1'b0; clr = 1'b0;
        check("sweep_busy_cycles", 32'(busy_cnt), 32'd32);
        check("sweep_drop_pulses", 32'(drop_cnt), 32'd1);
        for (int a = 0; a < DEPTH; a++) begin
            rd_a = {AW'(a), AW'(a)};
            rd_b = {AW'(a), AW'(a), AW'(a), AW'(a)};
            mid();
            check($sformatf("swept_A%0d", a), dout_a[63:32], 32'h0);
            check($sformatf("swept_B%0d", a), dout_b[31:0], 32'h0);
            step();
        end

        // 5: reset aborts a sweep
        wr(9, 32'h0000_0099, 4'hF);
        wr(20, 32'h2020_2020, 4'hF);
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (9) step();
        rd_a = {AW'(20), AW'(9)};
        rd_b = {AW'(0), AW'(0), AW'(9), AW'(20)};
        mid();
        check("presweep_reg20", dout_a[63:32], 32'h2020_2020);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy_a), 32'h0);
        check("abort_reg9_A", dout_a[31:0], 32'h0);
        check("abort_reg20_A", dout_a[63:32], 32'h0);
        check("abort_reg20_B", dout_b[31:0], 32'h0);
        step();
        step();
        rst_n = 1'b1;
        wr(9, 32'h1234_5678, 4'hF);
        mid();
        check("post_reset_write", dout_a[31:0], 32'h1234_5678);
        check("post_reset_busy", 32'(busy_a), 32'h0);
        step();

        // 6: reg0 on the ordinary-reg0 instance, all four ports
        wr(0, 32'h0000_0005, 4'hF);
        rd_a = {AW'(0), AW'(0)};
        rd_b = '0;
        mid();
        for (int p = 0; p < 4; p++)
            check($sformatf("reg0_B%0d", p), dout_b[p*DW +: DW], 32'h0000_0005);
        check("reg0_A_hardwired", dout_a[31:0], 32'h0);
        check("reg0_A_nodrop", 32'(drop_a), 32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
